// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared FSM state type, NOP default and load-counter width
package imem_responder_pkg;
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [31:0] NOP_DEFAULT = 32'h00000013;
    localparam int LOAD_CNT_W = 16;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-port synchronous RAM, registered read, read data holds on write or idle
// ports: clk, en (access), we (write), addr (word index), wdata, rdata (registered)
module imem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction memory with fetch port, debug-load port and bulk clear FSM
// ports: clk, rst_n (async active-low); fetch i_en/i_we/i_addr -> i_data;
//        debug d_valid/d_addr/d_wdata -> d_ready; c_clear -> o_busy; o_fault sticky; o_load_cnt
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_WORD    = NOP_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [31:0]           i_addr,
    output logic [31:0]           i_data,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    input  logic                  c_clear,
    output logic                  o_busy,
    output logic                  o_fault,
    output logic [LOAD_CNT_W-1:0] o_load_cnt
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic            src_ram;
    logic            idle, i_ok, d_ok, d_fire, fault_evt;
    logic            ram_en, ram_we;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     ram_wdata, ram_rdata;
    logic            unused_bits;
    assign unused_bits = ^{i_addr[1:0], d_addr[1:0]};
    assign idle      = state == IDLE;
    assign i_ok      = i_addr[31:AW+2] == '0;
    assign d_ok      = d_addr[31:AW+2] == '0;
    assign d_ready   = idle && !i_en;
    assign d_fire    = d_valid && d_ready;
    assign fault_evt = (i_en && (!i_ok || i_we)) || (d_fire && !d_ok);
    assign o_busy    = !idle;
    // the clear owns the port; otherwise a fetch reads and a debug handshake writes
    assign ram_en    = !idle || (i_en && i_ok) || (d_fire && d_ok);
    assign ram_we    = !idle || !i_en;
    assign ram_addr  = !idle ? clr_cnt : i_en ? i_addr[AW+1:2] : d_addr[AW+1:2];
    assign ram_wdata = !idle ? NOP_WORD : d_wdata;
    // src_ram remembers whether the last fetch was a real RAM read; RAM output holds otherwise
    assign i_data    = src_ram ? ram_rdata : NOP_WORD;
    imem_ram #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            src_ram    <= 1'b0;
            o_fault    <= 1'b0;
            o_load_cnt <= '0;
        end else begin
            if (i_en) src_ram <= idle && i_ok;
            if (d_fire) o_load_cnt <= o_load_cnt + 1'b1;
            // a fault in the same cycle as an accepted clear wins
            o_fault <= fault_evt || (o_fault && !(idle && c_clear));
            if (idle) begin
                if (c_clear) begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                end
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
                if (&clr_cnt) state <= IDLE;
            end
        end
    end
endmodule
